// File: rtl/seq_shifter.sv
// Iterative shifter: applies one shift-amount bit per clock (SLL/SRL/SRA/ROL) with valid/ready on both sides.
// Optional macro SEQ_SHIFTER_EARLY_EXIT_EN finishes as soon as no higher amount bits remain.
module seq_shifter #(
    parameter int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t                   state_q;
    logic [AMT_W-1:0]         k_q;
    logic [AMT_W-1:0]         amt_q;
    logic [1:0]               op_q;
    logic signed [WIDTH-1:0]  work_q;
    logic signed [WIDTH-1:0]  work_d;
    logic signed [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]         out_data_q;
    logic                     out_valid_q;
    logic [AMT_W:0]           sh;
    logic                     last;

    // One stage: shift the working register by 2^k when amt[k] is set.
    always_comb begin
        sh = (AMT_W+1)'(1) << k_q;
        case (op_q)
            OP_SLL:  shifted = work_q << sh;
            OP_SRL:  shifted = work_q >> sh;
            OP_SRA:  shifted = work_q >>> sh;
            default: shifted = (work_q << sh) | (work_q >> (WIDTH - sh));
        endcase
        work_d = amt_q[k_q] ? shifted : work_q;
    end

    // Stage k is the final one when it is the top bit, or (early exit) no higher bit is set.
    always_comb begin
        last = (k_q == AMT_W'(AMT_W - 1));
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
        if (((amt_q >> k_q) >> 1) == '0)
            last = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            k_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_data;
                        amt_q   <= in_amt;
                        op_q    <= in_op;
                        k_q     <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    k_q    <= k_q + 1'b1;
                    if (last) begin
                        out_data_q  <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and sweep bench for seq_shifter at WIDTH=32.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        case (op)
            2'd0:    return d << a;
            2'd1:    return d >> a;
            2'd2:    return 32'($signed(d) >>> a);
            default: return (a == 5'd0) ? d : ((d << a) | (d >> (6'd32 - {1'b0, a})));
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] a);
        int hi;
        hi = 0;
        for (int i = 0; i < 5; i++)
            if (a[i]) hi = i;
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
        return 1 + hi;
`else
        return 5;
`endif
    endfunction

    // Issue one request, count edges until out_valid, stall, then take the result.
    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input int stall, output logic [31:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_data = d; in_amt = a; in_op = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_op = ~op;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_sll();
        logic [31:0] r; int l;
        send(32'h0000_0001, 5'd5, 2'd0, 0, r, l);
        checks++;
        if (r !== 32'h0000_0020) begin errors++; $display("FAIL sll_data got %h want 00000020", r); end
        checks++;
        if (l !== exp_lat(5'd5)) begin errors++; $display("FAIL sll_latency got %0d want %0d", l, exp_lat(5'd5)); end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL sll_handshake_after got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sra_srl();
        logic [31:0] r; int l;
        send(32'h8000_0000, 5'd31, 2'd2, 0, r, l);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31 got %h want ffffffff", r); end
        checks++;
        if (l !== exp_lat(5'd31)) begin errors++; $display("FAIL sra31_latency got %0d want %0d", l, exp_lat(5'd31)); end
        send(32'h8000_0000, 5'd31, 2'd1, 0, r, l);
        checks++;
        if (r !== 32'h0000_0001) begin errors++; $display("FAIL srl31 got %h want 00000001", r); end
    endtask

    task automatic test_rol_zero();
        logic [31:0] r; int l;
        send(32'h8000_0001, 5'd1, 2'd3, 0, r, l);
        checks++;
        if (r !== 32'h0000_0003) begin errors++; $display("FAIL rol1 got %h want 00000003", r); end
        for (int op = 0; op < 4; op++) begin
            send(32'h8000_0001, 5'd0, 2'(op), 0, r, l);
            checks++;
            if (r !== 32'h8000_0001) begin errors++; $display("FAIL amt0_op%0d got %h want 80000001", op, r); end
            checks++;
            if (l !== exp_lat(5'd0)) begin errors++; $display("FAIL amt0_latency_op%0d got %0d want %0d", op, l, exp_lat(5'd0)); end
        end
    endtask

    task automatic test_backpressure();
        int w;
        in_data = 32'h0000_00F0; in_amt = 5'd4; in_op = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (w >= 50) begin errors++; $display("FAIL bp_timeout got no out_valid want out_valid within 50 cycles"); end
        in_valid = 1'b1; in_data = 32'h1234_5678; in_amt = 5'd1; in_op = 2'd3;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_0F00 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%0b data=%h ready=%0b want 1/00000f00/0", c, out_valid, out_data, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        repeat (8) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_stall_req_ignored got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r; int l;
        in_data = 32'h1234_5678; in_amt = 5'd3; in_op = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset got valid=%0b data=%h ready=%0b want 0/00000000/1", out_valid, out_data, in_ready);
        end
        send(32'h1234_5678, 5'd3, 2'd1, 1, r, l);
        checks++;
        if (r !== 32'h0246_8ACF) begin errors++; $display("FAIL midreset_next got %h want 02468acf", r); end
    endtask

    task automatic test_sweep();
        logic [31:0] r, d, e; int l; int pass;
        pass = 0;
        for (int i = 0; i <= 510; i += 37) begin
            for (int h = 0; h < 2; h++) begin
                d = (h == 1) ? (32'hA500_0000 | 32'(i)) : 32'(i);
                for (int a = 0; a < 32; a++) begin
                    for (int op = 0; op < 4; op++) begin
                        send(d, 5'(a), 2'(op), $urandom_range(0, 2), r, l);
                        e = model(d, 5'(a), 2'(op));
                        checks++;
                        if (r !== e || l !== exp_lat(5'(a))) begin
                            errors++;
                            $display("FAIL sweep d=%h amt=%0d op=%0d got %h lat %0d want %h lat %0d", d, a, op, r, l, e, exp_lat(5'(a)));
                        end else pass++;
                    end
                end
            end
        end
        $display("sweep score %0d matched", pass);
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_rol_zero();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
